ps2_mouse_packet_assembler: RTL and testbench



---
 rtl/ps2_mouse_pkg.sv | 29 ++
 rtl/ps2_mouse_packet_assembler_timer.sv | 40 ++++
 rtl/ps2_mouse_packet_assembler.sv | 152 +++++++++++++++
 tb/tb_ps2_mouse_packet_assembler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet path: FSM states, byte0
// field positions and small helpers.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        WAIT0 = 2'd0,   // waiting for a byte0 with the sync bit set
        GOT0  = 2'd1,   // byte0 held, waiting for the X byte
        GOT1  = 2'd2    // byte0 and byte1 held, waiting for the Y byte
    } state_t;

    // Bit positions inside byte0 of a standard mouse packet.
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    // Number of bytes in one packet.
    localparam int PKT_LEN = 3;

    // Increment an 8-bit counter, sticking at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ps2_mouse_packet_assembler_timer.sv
// Inter-byte timer: clearable, enableable up-counter that pulses
// 'expired' in the cycle it sits on TIMEOUT_CYCLES-1 while enabled.
module ps2_byte_timer #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = en && !clr && (cnt_q == LAST);

    // Next count: clear wins, restart after expiry, otherwise count when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || expired) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_assembler.sv
// Assembles 3-byte PS/2 mouse packets from the receiver byte stream, with
// sync recovery, inter-byte timeout, read handshake and error accounting.
module ps2_mouse_packet_assembler
    import ps2_mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rx_error,
    output logic       left_button,
    output logic       right_button,
    output logic       middle_button,
    output logic [8:0] x_increment,
    output logic [8:0] y_increment,
    output logic       x_overflow,
    output logic       y_overflow,
    output logic       data_ready,
    input  logic       read,
    output logic       overrun,
    output logic [7:0] sync_errors
);

    state_t     state_q, state_d;
    logic [7:0] byte0_q, byte0_d;        // holding registers for the partial packet
    logic [7:0] byte1_q, byte1_d;
    logic [7:0] out_b0_q, out_b0_d;      // committed packet driving the outputs
    logic [7:0] out_b1_q, out_b1_d;
    logic [7:0] out_b2_q, out_b2_d;
    logic       data_ready_q, data_ready_d;
    logic       overrun_q, overrun_d;
    logic [7:0] sync_errors_q, sync_errors_d;

    logic       timer_clr;
    logic       timer_en;
    logic       timer_expired;
    logic       commit;
    logic       err_inc;

    // The timer only runs while a packet is partially received and restarts
    // on every byte, so it measures the gap between consecutive bytes.
    assign timer_clr = rx_valid || rx_error || (state_q == WAIT0);
    assign timer_en  = (state_q != WAIT0);

    ps2_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Packet FSM and output update: error beats a byte, a byte beats timeout,
    // and a commit beats a simultaneous read.
    always_comb begin
        state_d       = state_q;
        byte0_d       = byte0_q;
        byte1_d       = byte1_q;
        out_b0_d      = out_b0_q;
        out_b1_d      = out_b1_q;
        out_b2_d      = out_b2_q;
        data_ready_d  = data_ready_q;
        overrun_d     = overrun_q;
        commit        = 1'b0;
        err_inc       = 1'b0;

        if (rx_error) begin
            state_d = WAIT0;
            err_inc = (state_q != WAIT0);
        end else if (rx_valid) begin
            case (state_q)
                WAIT0: begin
                    if (rx_byte[SYNC]) begin
                        state_d = GOT0;
                        byte0_d = rx_byte;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                GOT0: begin
                    state_d = GOT1;
                    byte1_d = rx_byte;
                end
                GOT1: begin
                    state_d = WAIT0;
                    commit  = 1'b1;
                end
                default: state_d = WAIT0;
            endcase
        end else if (timer_expired) begin
            state_d = WAIT0;
            err_inc = 1'b1;
        end

        if (commit) begin
            out_b0_d     = byte0_q;
            out_b1_d     = byte1_q;
            out_b2_d     = rx_byte;
            data_ready_d = 1'b1;
            if (data_ready_q && !read) begin
                overrun_d = 1'b1;
            end
        end else if (read) begin
            data_ready_d = 1'b0;
        end

        sync_errors_d = err_inc ? sat_inc8(sync_errors_q) : sync_errors_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= WAIT0;
            byte0_q       <= '0;
            byte1_q       <= '0;
            out_b0_q      <= '0;
            out_b1_q      <= '0;
            out_b2_q      <= '0;
            data_ready_q  <= 1'b0;
            overrun_q     <= 1'b0;
            sync_errors_q <= '0;
        end else begin
            state_q       <= state_d;
            byte0_q       <= byte0_d;
            byte1_q       <= byte1_d;
            out_b0_q      <= out_b0_d;
            out_b1_q      <= out_b1_d;
            out_b2_q      <= out_b2_d;
            data_ready_q  <= data_ready_d;
            overrun_q     <= overrun_d;
            sync_errors_q <= sync_errors_d;
        end
    end

    assign left_button   = out_b0_q[BTN_L];
    assign right_button  = out_b0_q[BTN_R];
    assign middle_button = out_b0_q[BTN_M];
    assign x_increment   = {out_b0_q[XSIGN], out_b1_q};
    assign y_increment   = {out_b0_q[YSIGN], out_b2_q};
    assign x_overflow    = out_b0_q[XOVF];
    assign y_overflow    = out_b0_q[YOVF];
    assign data_ready    = data_ready_q;
    assign overrun       = overrun_q;
    assign sync_errors   = sync_errors_q;

endmodule

// File: tb/tb_ps2_mouse_packet_assembler.sv
// Bench for ps2_mouse_packet_assembler: table of packets, hand-written
// corner sequences, then randomized traffic against a packet-level model.
module tb_ps2_mouse_packet_assembler;

    localparam int T = 20;

    logic       Clk;
    logic       Reset;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_error;
    logic       left_button, right_button, middle_button;
    logic [8:0] x_increment, y_increment;
    logic       x_overflow, y_overflow;
    logic       data_ready;
    logic       read;
    logic       overrun;
    logic [7:0] sync_errors;

    int tests  = 0;
    int failed = 0;

    ps2_mouse_packet_assembler #(
        .TIMEOUT_CYCLES (T),
        .CNT_W          (8)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .rx_error      (rx_error),
        .left_button   (left_button),
        .right_button  (right_button),
        .middle_button (middle_button),
        .x_increment   (x_increment),
        .y_increment   (y_increment),
        .x_overflow    (x_overflow),
        .y_overflow    (y_overflow),
        .data_ready    (data_ready),
        .read          (read),
        .overrun       (overrun),
        .sync_errors   (sync_errors)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- packet-level reference model ----------------
    logic [7:0] mq[$];          // bytes of the packet being collected
    int         m_idle;         // idle cycles since the last byte of a partial packet
    logic [7:0] m_b0, m_b1, m_b2;
    bit         m_ready, m_ovr;
    int         m_err;

    task automatic model_step();
        bit commit;
        commit = 0;
        if (Reset) begin
            mq.delete();
            m_idle = 0; m_b0 = 0; m_b1 = 0; m_b2 = 0;
            m_ready = 0; m_ovr = 0; m_err = 0;
            return;
        end
        if (rx_error) begin
            if (mq.size() > 0 && m_err < 255) m_err++;
            mq.delete();
            m_idle = 0;
        end else if (rx_valid) begin
            m_idle = 0;
            if (mq.size() == 0 && !rx_byte[3]) begin
                if (m_err < 255) m_err++;
            end else begin
                mq.push_back(rx_byte);
                if (mq.size() == 3) begin
                    commit = 1;
                    m_b0 = mq[0]; m_b1 = mq[1]; m_b2 = mq[2];
                    mq.delete();
                end
            end
        end else if (mq.size() > 0) begin
            m_idle++;
            if (m_idle >= T) begin
                mq.delete();
                m_idle = 0;
                if (m_err < 255) m_err++;
            end
        end
        if (commit) begin
            if (m_ready && !read) m_ovr = 1;
            m_ready = 1;
        end else if (read) begin
            m_ready = 0;
        end
    endtask

    function automatic logic [39:0] model_vec();
        logic [7:0] e;
        e = m_err[7:0];
        return {7'd0, m_b0[0], m_b0[1], m_b0[2], m_b0[4], m_b1, m_b0[5], m_b2,
                m_b0[6], m_b0[7], m_ready, m_ovr, e};
    endfunction

    function automatic logic [39:0] dut_vec();
        return {7'd0, left_button, right_button, middle_button, x_increment, y_increment,
                x_overflow, y_overflow, data_ready, overrun, sync_errors};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic rd);
        rx_byte = b; rx_valid = 1'b1; read = rd;
        cycle();
        rx_valid = 1'b0; read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cycle();
        cycle();
        Reset = 1'b0;
    endtask

    task automatic pulse_read();
        read = 1'b1;
        cycle();
        read = 1'b0;
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic       l, r, m;
        logic [8:0] x, y;
        logic       xo, yo;
    } vec_t;

    vec_t vt[6];

    initial begin
        Reset = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; rx_error = 1'b0; read = 1'b0;

        vt[0] = '{8'h09, 8'h05, 8'hFB, 1, 0, 0, 9'h005, 9'h0FB, 0, 0};
        vt[1] = '{8'h29, 8'h05, 8'hFB, 1, 0, 0, 9'h005, 9'h1FB, 0, 0};
        vt[2] = '{8'h08, 8'h01, 8'h02, 0, 0, 0, 9'h001, 9'h002, 0, 0};
        vt[3] = '{8'h3E, 8'hFF, 8'h80, 0, 1, 1, 9'h1FF, 9'h180, 0, 0};
        vt[4] = '{8'hC8, 8'h7F, 8'h01, 0, 0, 0, 9'h07F, 9'h001, 1, 1};
        vt[5] = '{8'h1F, 8'h00, 8'h00, 1, 1, 1, 9'h100, 9'h000, 0, 0};

        do_reset();
        check("reset_outputs", dut_vec(), 40'd0);

        // Table-driven packets, each committed and acknowledged.
        for (int i = 0; i < 6; i++) begin
            send(vt[i].b0, 1'b0);
            send(vt[i].b1, 1'b0);
            check("ready_before_byte2", {39'd0, data_ready}, 40'd0);
            send(vt[i].b2, 1'b0);
            check("ready_after_byte2", {39'd0, data_ready}, 40'd1);
            check("fields",
                  {15'd0, left_button, right_button, middle_button, x_increment, y_increment,
                   x_overflow, y_overflow},
                  {15'd0, vt[i].l, vt[i].r, vt[i].m, vt[i].x, vt[i].y, vt[i].xo, vt[i].yo});
            pulse_read();
            check("ready_cleared_by_read", {39'd0, data_ready}, 40'd0);
            $display("[TB] packet %0d: %02h %02h %02h -> x=%03h y=%03h", i,
                     vt[i].b0, vt[i].b1, vt[i].b2, x_increment, y_increment);
        end
        check("no_overrun_after_reads", {39'd0, overrun}, 40'd0);
        check("no_sync_errors_table", {32'd0, sync_errors}, 40'd0);

        // Misaligned byte discarded, next packet aligns.
        do_reset();
        send(8'h00, 1'b0);
        check("misaligned_count", {32'd0, sync_errors}, 40'd1);
        send(8'h08, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
        check("realigned_xy", {22'd0, x_increment, y_increment}, {22'd0, 9'h001, 9'h002});
        check("realigned_ready", {39'd0, data_ready}, 40'd1);
        $display("[TB] misaligned byte then packet, sync_errors=%0d", sync_errors);

        // Inter-byte timeout at exactly T idle cycles.
        do_reset();
        send(8'h18, 1'b0); send(8'h10, 1'b0);
        idle(T - 1);
        check("timeout_not_yet", {32'd0, sync_errors}, 40'd0);
        idle(1);
        check("timeout_count", {32'd0, sync_errors}, 40'd1);
        check("timeout_no_commit", {39'd0, data_ready}, 40'd0);
        send(8'h08, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        check("after_timeout_commit", {21'd0, data_ready, x_increment, y_increment},
              {21'd0, 1'b1, 9'h000, 9'h000});
        $display("[TB] timeout sequence, sync_errors=%0d", sync_errors);

        // Overrun: two packets with no read.
        do_reset();
        send(8'h08, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
        send(8'h08, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        check("overrun_values", {20'd0, data_ready, overrun, x_increment, y_increment},
              {20'd0, 1'b1, 1'b1, 9'h003, 9'h004});
        $display("[TB] overwrite without read, overrun=%0d", overrun);

        // Read on the commit cycle: commit wins, no overrun.
        do_reset();
        send(8'h08, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
        send(8'h08, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
        check("read_on_commit", {20'd0, data_ready, overrun, x_increment, y_increment},
              {20'd0, 1'b1, 1'b0, 9'h003, 9'h004});
        $display("[TB] overwrite with read on commit, overrun=%0d", overrun);

        // rx_error after byte1 aborts the packet; in WAIT0 it is not counted.
        do_reset();
        rx_error = 1'b1; cycle(); rx_error = 1'b0;
        check("error_in_wait0", {32'd0, sync_errors}, 40'd0);
        send(8'h08, 1'b0); send(8'h01, 1'b0);
        rx_error = 1'b1; rx_valid = 1'b1; rx_byte = 8'h09; cycle();
        rx_error = 1'b0; rx_valid = 1'b0;
        check("error_after_byte1", {32'd0, sync_errors}, 40'd1);
        send(8'h08, 1'b0); send(8'h05, 1'b0); send(8'h06, 1'b0);
        check("after_error_commit", {21'd0, data_ready, x_increment, y_increment},
              {21'd0, 1'b1, 9'h005, 9'h006});
        $display("[TB] rx_error mid-packet, sync_errors=%0d", sync_errors);

        // Saturation of the error counter.
        do_reset();
        for (int i = 0; i < 300; i++) send(8'h00, 1'b0);
        check("sync_saturate", {32'd0, sync_errors}, 40'hFF);
        $display("[TB] 300 misaligned bytes, sync_errors=%0d", sync_errors);

        // Reset during GOT1 clears everything, no commit afterwards.
        send(8'h09, 1'b0); send(8'h05, 1'b0); send(8'h06, 1'b0);
        send(8'h08, 1'b0); send(8'h07, 1'b0);
        Reset = 1'b1; cycle(); Reset = 1'b0;
        check("reset_mid_packet", dut_vec(), 40'd0);
        send(8'h10, 1'b0);
        check("after_reset_wait0", {31'd0, data_ready, sync_errors}, {31'd0, 1'b0, 8'd1});
        $display("[TB] reset during GOT1");

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                int n;
                n = $urandom_range(T - 2, T + 2);
                rx_valid = 1'b0; rx_error = 1'b0;
                for (int k = 0; k < n; k++) begin
                    read = ($urandom_range(0, 4) == 0);
                    cycle();
                    check("random_idle", dut_vec(), model_vec());
                end
            end
            rx_valid = $urandom_range(0, 1);
            rx_byte  = 8'($urandom);
            if ($urandom_range(0, 4) != 0) rx_byte[3] = 1'b1;
            rx_error = ($urandom_range(0, 31) == 0);
            read     = ($urandom_range(0, 4) == 0);
            cycle();
            check("random", dut_vec(), model_vec());
        end
        rx_valid = 1'b0; rx_error = 1'b0; read = 1'b0;
        $display("[TB] random phase done, sync_errors=%0d overrun=%0d", sync_errors, overrun);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
